// File: rtl/scoreboard_unit_pkg.sv
// Shared core definitions for the register scoreboard: register-id width,
// default register count and the register-id type.
package scoreboard_unit_pkg;
  localparam int REG_ID_W     = 6;
  localparam int NUM_REGS_DEF = 64;
  localparam int CNT_W        = 7;

  typedef logic [REG_ID_W-1:0] reg_id_t;
endpackage

// File: rtl/scoreboard_unit.sv
// Register scoreboard: tracks outstanding long-latency writes and stalls ID on
// RAW/WAW hazards or a full pending pool. Optional SCOREBOARD_STALL_CNT_EN adds
// a saturating stall_cycles counter.
module scoreboard_unit
  import scoreboard_unit_pkg::*;
#(
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int MAX_PENDING = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  reg_id_t             issue_rd,
  input  logic                issue_reg_write,
  input  logic                issue_long,
  input  reg_id_t             rs1_id,
  input  reg_id_t             rs2_id,
  input  logic                flush,
  input  logic                wb_valid,
  input  reg_id_t             wb_rd,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [CNT_W-1:0]    pending_cnt,
  output logic                wb_err
`ifdef SCOREBOARD_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  logic                hit_rs1_s;
  logic                hit_rs2_s;
  logic                hit_rd_s;
  logic                pool_full_s;
  logic                clear_s;
  logic                wb_bad_s;
  logic                accept_s;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] clr_mask_s;
  logic [CNT_W-1:0]    next_cnt_s;

  // Hazard detection; a same-cycle writeback resolves the hazard on that register.
  always_comb begin
    hit_rs1_s = (rs1_id != 6'd0) && busy_vec[rs1_id] && !(wb_valid && (wb_rd == rs1_id));
    hit_rs2_s = (rs2_id != 6'd0) && busy_vec[rs2_id] && !(wb_valid && (wb_rd == rs2_id));
    hit_rd_s  = (issue_rd != 6'd0) && busy_vec[issue_rd] && !(wb_valid && (wb_rd == issue_rd));
    clear_s   = wb_valid && (wb_rd != 6'd0) && busy_vec[wb_rd];
    wb_bad_s  = wb_valid && ((wb_rd == 6'd0) || !busy_vec[wb_rd]);
    pool_full_s = issue_long && issue_reg_write && (issue_rd != 6'd0) &&
                  (pending_cnt == CNT_W'(MAX_PENDING)) && !clear_s;
    if (issue_valid && !flush) begin
      stall = hit_rs1_s || hit_rs2_s || (issue_reg_write && hit_rd_s) || pool_full_s;
    end else begin
      stall = 1'b0;
    end
    accept_s = issue_valid && !stall && !flush && issue_long && issue_reg_write &&
               (issue_rd != 6'd0);
  end

  // Next-state masks and count; set is applied after clear so a same-register
  // accept+clear leaves the bit set with a net-zero count change.
  always_comb begin
    set_mask_s = {NUM_REGS{1'b0}};
    clr_mask_s = {NUM_REGS{1'b0}};
    if (accept_s) begin
      set_mask_s = {{(NUM_REGS-1){1'b0}}, 1'b1} << issue_rd;
    end else begin
      set_mask_s = {NUM_REGS{1'b0}};
    end
    if (clear_s) begin
      clr_mask_s = {{(NUM_REGS-1){1'b0}}, 1'b1} << wb_rd;
    end else begin
      clr_mask_s = {NUM_REGS{1'b0}};
    end
    case ({accept_s, clear_s})
      2'b10:   next_cnt_s = pending_cnt + 7'd1;
      2'b01:   next_cnt_s = pending_cnt - 7'd1;
      default: next_cnt_s = pending_cnt;
    endcase
  end

  // Scoreboard state registers; flush deliberately leaves in-flight entries alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec     <= {NUM_REGS{1'b0}};
      pending_cnt  <= 7'd0;
      wb_err       <= 1'b0;
`ifdef SCOREBOARD_STALL_CNT_EN
      stall_cycles <= 32'd0;
`endif
    end else begin
      busy_vec    <= (busy_vec & ~clr_mask_s) | set_mask_s;
      pending_cnt <= next_cnt_s;
      wb_err      <= wb_err | wb_bad_s;
`ifdef SCOREBOARD_STALL_CNT_EN
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end else begin
        stall_cycles <= stall_cycles;
      end
`endif
    end
  end

endmodule

// File: tb/tb_scoreboard_unit.sv
// Self-checking bench for scoreboard_unit: directed scenarios with literal
// expectations plus randomized traffic against a set-based reference model.
module tb_scoreboard_unit;
  import scoreboard_unit_pkg::*;

  localparam int MAXP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_reg_write, issue_long, flush, wb_valid;
  reg_id_t     issue_rd, rs1_id, rs2_id, wb_rd;
  logic        stall;
  logic [63:0] busy_vec;
  logic [6:0]  pending_cnt;
  logic        wb_err;
`ifdef SCOREBOARD_STALL_CNT_EN
  logic [31:0] stall_cycles;
  longint      m_stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  bit mbusy[64];
  bit merr;
  logic last_stall;

  scoreboard_unit #(.NUM_REGS(64), .MAX_PENDING(MAXP)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_reg_write(issue_reg_write),
    .issue_long(issue_long), .rs1_id(rs1_id), .rs2_id(rs2_id), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .stall(stall), .busy_vec(busy_vec),
    .pending_cnt(pending_cnt), .wb_err(wb_err)
`ifdef SCOREBOARD_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 64; i++) n += mbusy[i];
    return n;
  endfunction

  function automatic logic [63:0] m_vec();
    logic [63:0] v = 64'd0;
    for (int i = 0; i < 64; i++) v[i] = mbusy[i];
    return v;
  endfunction

  function automatic bit m_hazard(input int r);
    return (r != 0) && mbusy[r] && !(wb_valid && (int'(wb_rd) == r));
  endfunction

  function automatic bit m_stall();
    bit frees, full;
    if (!issue_valid || flush) return 1'b0;
    frees = wb_valid && (wb_rd != 6'd0) && mbusy[wb_rd];
    full  = issue_long && issue_reg_write && (issue_rd != 6'd0) && (m_count() == MAXP) && !frees;
    return m_hazard(rs1_id) || m_hazard(rs2_id) || (issue_reg_write && m_hazard(issue_rd)) || full;
  endfunction

  // Apply one clock edge of the model using the inputs currently driven.
  task automatic m_edge();
    bit st, acc;
    st  = m_stall();
    acc = issue_valid && !st && !flush && issue_long && issue_reg_write && (issue_rd != 6'd0);
`ifdef SCOREBOARD_STALL_CNT_EN
    if (st && m_stall_cycles < 64'hFFFF_FFFF) m_stall_cycles++;
`endif
    if (wb_valid) begin
      if (wb_rd != 6'd0 && mbusy[wb_rd]) mbusy[wb_rd] = 1'b0;
      else merr = 1'b1;
    end
    if (acc) mbusy[issue_rd] = 1'b1;
  endtask

  task automatic chk_regs();
    chk("busy_vec", busy_vec, m_vec());
    chk("pending_cnt", 64'(pending_cnt), 64'(m_count()));
    chk("wb_err", 64'(wb_err), 64'(merr));
`ifdef SCOREBOARD_STALL_CNT_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall_cycles));
`endif
  endtask

  // One cycle: drive, compare combinational stall, clock, compare registers.
  task automatic cyc(input bit iv, input int rd, input bit rw, input bit lg,
                     input int r1, input int r2, input bit fl, input bit wv, input int wr);
    issue_valid = iv; issue_rd = 6'(rd); issue_reg_write = rw; issue_long = lg;
    rs1_id = 6'(r1); rs2_id = 6'(r2); flush = fl; wb_valid = wv; wb_rd = 6'(wr);
    #1;
    chk("stall", 64'(stall), 64'(m_stall()));
    last_stall = stall;
    @(posedge clk);
    m_edge();
    #1;
    chk_regs();
  endtask

  task automatic idle();
    cyc(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset(input bit probe);
    issue_valid = probe; issue_rd = 6'd3; issue_reg_write = 1'b1; issue_long = 1'b0;
    rs1_id = 6'd8; rs2_id = 6'd0; flush = 1'b0; wb_valid = 1'b0; wb_rd = 6'd0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) mbusy[i] = 1'b0;
    merr = 1'b0;
`ifdef SCOREBOARD_STALL_CNT_EN
    m_stall_cycles = 0;
`endif
    chk("rst_busy", busy_vec, 64'd0);
    chk("rst_cnt", 64'(pending_cnt), 64'd0);
    chk("rst_err", 64'(wb_err), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int wv, wr, rd, nb;
    do_reset(1'b0);

    // Load rd=5, dependent consumer stalls until the writeback cycle.
    cyc(1'b1, 5, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 0);
    chk("load_busy5", 64'(busy_vec[5]), 64'd1);
    cyc(1'b1, 10, 1'b1, 1'b0, 5, 0, 1'b0, 1'b0, 0);
    chk("raw_stall", 64'(last_stall), 64'd1);
    cyc(1'b1, 10, 1'b1, 1'b0, 5, 0, 1'b0, 1'b0, 0);
    chk("raw_stall2", 64'(last_stall), 64'd1);
    cyc(1'b1, 10, 1'b1, 1'b0, 5, 0, 1'b0, 1'b1, 5);
    chk("wb_resolves", 64'(last_stall), 64'd0);
    chk("wb_cnt0", 64'(pending_cnt), 64'd0);

    // Long write to r0 is not tracked.
    cyc(1'b1, 0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 0);
    chk("r0_stall", 64'(last_stall), 64'd0);
    chk("r0_busy", busy_vec, 64'd0);
    chk("r0_cnt", 64'(pending_cnt), 64'd0);

    // Fill the pending pool, then a freeing writeback lets the fifth in.
    for (int r = 1; r <= 4; r++) cyc(1'b1, r, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 0);
    chk("full_cnt", 64'(pending_cnt), 64'd4);
    cyc(1'b1, 6, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 0);
    chk("full_stall", 64'(last_stall), 64'd1);
    chk("full_cnt_hold", 64'(pending_cnt), 64'd4);
    cyc(1'b1, 6, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1);
    chk("full_free_stall", 64'(last_stall), 64'd0);
    chk("full_free_cnt", 64'(pending_cnt), 64'd4);
    chk("full_free_vec", busy_vec, 64'h0000_0000_0000_005C);
    foreach (mbusy[i]) if (mbusy[i]) cyc(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, i);

    // Clear 7 while accepting 8; then same-register accept and clear on 8.
    cyc(1'b1, 7, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 0);
    cyc(1'b1, 8, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 7);
    chk("swap_vec", busy_vec, 64'h0000_0000_0000_0100);
    chk("swap_cnt", 64'(pending_cnt), 64'd1);
    cyc(1'b1, 8, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 8);
    chk("same_stall", 64'(last_stall), 64'd0);
    chk("same_vec", busy_vec, 64'h0000_0000_0000_0100);
    chk("same_cnt", 64'(pending_cnt), 64'd1);

    // Flush kills an acceptable issue but keeps existing bits.
    cyc(1'b1, 9, 1'b1, 1'b1, 8, 0, 1'b1, 1'b0, 0);
    chk("flush_stall", 64'(last_stall), 64'd0);
    chk("flush_vec", busy_vec, 64'h0000_0000_0000_0100);

    // Writeback to a clear register is a sticky error; reset clears everything.
    cyc(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 9);
    chk("err_set", 64'(wb_err), 64'd1);
    chk("err_cnt", 64'(pending_cnt), 64'd1);
    idle();
    chk("err_sticky", 64'(wb_err), 64'd1);
    do_reset(1'b1);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset($urandom_range(0, 1) == 1);
      nb = m_count();
      wv = ($urandom_range(0, 2) == 0 && nb > 0) || ($urandom_range(0, 79) == 0) ? 1 : 0;
      wr = $urandom_range(0, 11);
      if (wv == 1 && nb > 0 && $urandom_range(0, 39) != 0) begin
        rd = $urandom_range(0, nb - 1);
        foreach (mbusy[i]) if (mbusy[i]) begin
          if (rd == 0) wr = i;
          rd--;
        end
      end
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 11), $urandom_range(0, 4) != 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 11), $urandom_range(0, 11),
          $urandom_range(0, 15) == 0, wv == 1, wr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
